// File: rtl/pes_reverse_pipe_if.sv
// Valid/ready stream bundle for pes_reverse_pipe: input word with its transform
// mode on one side, transformed word on the other.
interface pes_reverse_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pes_reverse_pipe.sv
// Bit/group reversal applied on input transfer, held in a 2-entry in-order
// buffer whose head drives the output straight from registers.
module pes_reverse_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  pes_reverse_pipe_if.slave bus,
  output logic [CNT_W-1:0] xfer_cnt
);

  if (WIDTH < 2 || GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_params
    $error("pes_reverse_pipe: illegal WIDTH=%0d / GROUP=%0d", WIDTH, GROUP);
  end

  localparam int NGRP = WIDTH / GROUP;

  function automatic logic [WIDTH-1:0] xform(input logic [WIDTH-1:0] d,
                                             input logic [1:0]       m);
    logic [WIDTH-1:0] r;
    r = d;
    case (m)
      2'd1: for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
      2'd2: for (int k = 0; k < NGRP; k++) r[(NGRP-1-k)*GROUP +: GROUP] = d[k*GROUP +: GROUP];
      2'd3: for (int k = 0; k < NGRP; k++)
              for (int j = 0; j < GROUP; j++) r[k*GROUP+j] = d[k*GROUP+GROUP-1-j];
      default: r = d;
    endcase
    return r;
  endfunction

  logic [1:0]       cnt_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] head_p1;
  logic [WIDTH-1:0] tail_p1;
  logic [WIDTH-1:0] xf_p0;
  logic             push;
  logic             pop;

  // Stage p0: transform on the way in; ready depends only on occupancy and reset
  assign xf_p0        = xform(bus.in_data, bus.in_mode);
  assign bus.in_ready = nrst && (cnt_p1 != 2'd2);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = vld_p1 && bus.out_ready;

  // Stage p1: storage; push and pop together can only happen at occupancy 1
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_p1   <= 2'd0;
      vld_p1   <= 1'b0;
      head_p1  <= '0;
      tail_p1  <= '0;
      xfer_cnt <= '0;
    end else begin
      if (pop) xfer_cnt <= xfer_cnt + CNT_W'(1);
      case ({push, pop})
        2'b10: begin
          if (cnt_p1 == 2'd0) head_p1 <= xf_p0;
          else                tail_p1 <= xf_p0;
          cnt_p1 <= cnt_p1 + 2'd1;
          vld_p1 <= 1'b1;
        end
        2'b01: begin
          if (cnt_p1 == 2'd2) head_p1 <= tail_p1;
          cnt_p1 <= cnt_p1 - 2'd1;
          vld_p1 <= (cnt_p1 == 2'd2);
        end
        2'b11: head_p1 <= xf_p0;
        default: ;
      endcase
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = head_p1;

endmodule

// File: doc/pes_reverse_pipe.md
PES_REVERSE_PIPE -- requirements
Module: pes_reverse_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16: data bus width in bits; legal when WIDTH >= 2.
REQ-002 The module SHALL have parameter GROUP, default 8: group size in bits for the group modes; legal when GROUP >= 1 and WIDTH % GROUP == 0.
REQ-003 The module SHALL have parameter CNT_W, default 16: width of the transfer counter.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port nrst, input, 1 bit: synchronous, active-low reset.
REQ-006 The module SHALL have port in_valid, input, 1 bit: upstream word valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit: block can accept a word this cycle.
REQ-008 The module SHALL have port in_data, input, WIDTH bits: input word.
REQ-009 The module SHALL have port in_mode, input, 2 bits: transform for this word, sampled together with in_data.
REQ-010 The module SHALL have port out_valid, output, 1 bit: output word valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-012 The module SHALL have port out_data, output, WIDTH bits: transformed word.
REQ-013 The module SHALL have port xfer_cnt, output, CNT_W bits: count of completed output transfers.

Function
REQ-014 Input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-015 Transform by in_mode SHALL be: 0 = pass-through; 1 = full bit reverse, out[i] = in[WIDTH-1-i]; 2 = group-order reverse, group k moves to group (WIDTH/GROUP-1-k) with bit order inside each group kept; 3 = bit reverse within each group, group positions kept.
REQ-016 The transform SHALL be applied at input transfer, and the transformed word SHALL be stored; in_mode SHALL have no effect on words already stored.
REQ-017 Storage SHALL be a 2-entry in-order buffer with occupancy count 0..2; out_data SHALL show the head entry.
REQ-018 in_ready SHALL equal (count < 2) and nrst=1, and SHALL have no combinational path from out_ready.
REQ-019 out_valid SHALL equal (count > 0); out_data and out_valid SHALL come from registers only.
REQ-020 Latency: a word accepted in cycle N into an empty buffer SHALL appear with out_valid=1 in cycle N+1.
REQ-021 With out_ready held at 1, the block SHALL sustain one word per cycle.
REQ-022 Simultaneous push and pop at count=1 SHALL leave count at 1, with the new word becoming head in the next cycle.
REQ-023 A push with no pop SHALL increment count; a pop with no push SHALL decrement count.
REQ-024 At count=2, in_ready SHALL be 0, no push SHALL occur, and a pop SHALL reduce count to 1.
REQ-025 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 xfer_cnt SHALL increment by 1 per output transfer and SHALL wrap from 2^CNT_W-1 to 0.
REQ-027 When GROUP == WIDTH, mode 2 SHALL equal mode 0 and mode 3 SHALL equal mode 1.
REQ-028 Illegal parameter combinations SHALL stop elaboration with an error.

Reset
REQ-029 When nrst=0 at a rising clk edge, the block SHALL clear count to 0, out_valid to 0, out_data to 0 and xfer_cnt to 0.
REQ-030 in_ready SHALL be 0 while nrst=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored words, with no output transfer in that cycle.
REQ-032 The first input transfer SHALL be possible in the first cycle with nrst=1.

Verification (WIDTH=16, GROUP=8)
REQ-033 The bench SHALL check modes: 0x12A5 sent in modes 0/1/2/3 with out_ready=1 -> out_data 0x12A5 / 0xA548 / 0xA512 / 0x48A5, each one cycle after acceptance.
REQ-034 The bench SHALL check backpressure: out_ready=0, 3 words offered -> first 2 accepted, in_ready=0 afterwards, out_data stable at word 1; out_ready=1 -> words delivered in order, in_ready=1 the next cycle.
REQ-035 The bench SHALL check streaming: 100 back-to-back words with out_ready=1 -> 100 output transfers in 101 cycles, xfer_cnt=100.
REQ-036 The bench SHALL check wrap: with CNT_W=4, 17 transfers -> xfer_cnt = 1.
REQ-037 The bench SHALL check reset mid-stream: count=2, nrst=0 for one cycle -> out_valid=0, out_data=0x0000, xfer_cnt=0, and no stale word emitted afterwards.
